axi_read_master: RTL and testbench
==================================

Name: axi_read_master

Overview:
AXI4 read-channel initiator: accepts a (address, length, id) read command and issues aligned INCR bursts on AR. It collects the R beats into a registered valid/ready output stream and reports completion and errors. It is the requesting end of an AXI4 slave memory port, used by the prefetch engine to pull lines from backing RAM. One command is in flight at a time; a command crossing a 4 KB boundary is split into two bursts.

Parameters:
DATA_WIDTH, 32, AXI data bus width in bits
ADDR_WIDTH, 16, AXI address width in bits
STRB_WIDTH, DATA_WIDTH/8, bytes per beat; must be a power of two
ID_WIDTH, 8, AXI ID width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_addr  in  ADDR_WIDTH  byte start address; low log2(STRB_WIDTH) bits ignored
cmd_len  in  8  beats minus one (0..255)
cmd_id  in  ID_WIDTH  AXI ID for all bursts of the command
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
m_axi_arid / araddr / arlen  out  ID_WIDTH / ADDR_WIDTH / 8  AR payload
m_axi_arsize  out  3  constant log2(STRB_WIDTH)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arlock / arcache / arprot  out  1 / 4 / 3  constants 0 / 4'b0011 / 0
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid / rdata / rresp / rlast / rvalid  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  R channel
m_axi_rready  out  1  R ready
out_data  out  DATA_WIDTH  read data beat
out_last  out  1  final beat of the whole command
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
done  out  1  one-cycle pulse when the command's final beat is transferred on R
err  out  1  error status for the command; valid in the same cycle as done; held until next command accept
busy  out  1  high from cmd accept until done

Behaviour:
- Reset values: cmd_ready=0 in the reset cycle, 1 in the first cycle after reset; arvalid=0; out_valid=0; out_last=0; done=0; err=0; busy=0; state=IDLE. All AR payload registers are reset to 0.
- States: IDLE, ADDR, DATA.
- IDLE: cmd_ready=1 (registered). On accept: latch id, aligned addr A = cmd_addr with low log2(STRB_WIDTH) bits cleared, and total beats N = cmd_len+1. Set cmd_ready=0, busy=1, err=0. Go to ADDR. arvalid rises on the next cycle.
- Burst sizing: beats available to the 4 KB boundary B = (4096 - A[11:0]) / STRB_WIDTH. If N > B, first burst arlen = B-1 and a second burst of N-B beats starts at A + B*STRB_WIDTH. Otherwise there is a single burst with arlen = N-1. Only INCR bursts are issued. Address arithmetic is modulo 2^ADDR_WIDTH.
- ADDR: arvalid=1 with a stable payload until arready. On handshake: arvalid=0 on the next cycle; go to DATA.
- DATA: m_axi_rready = (state==DATA) && (!out_valid || out_ready), combinational.
  - Each R handshake loads out_data, sets out_valid=1, and decrements the burst beat counter.
  - out_valid clears on out_ready when no new beat is loaded that cycle.
  - Throughput: 1 beat/cycle when out_ready is held high.
- Per-beat checks; any failure sets err (sticky for the command):
  - rresp != 0;
  - rid != latched id;
  - rlast asserted before the burst's final beat;
  - rlast low on the burst's final beat.
- A burst ends on its counted final beat regardless of rlast.
- After the first of two split bursts, return to ADDR for the second; the first burst's final beat has out_last=0.
- On the command's final beat: out_last=1 with that beat; done pulses 1 cycle in the same cycle arvalid-free, R handshake registered (done is asserted the cycle after the R handshake); busy=0, cmd_ready=1 that same cycle; state returns to IDLE.
- A new command may be accepted while the final out beat is still stalled. The R side does not advance until out is drained, so no beat is lost.
- R beats presented outside DATA are not accepted (rready=0).
- rst mid-operation: immediately returns to the reset values. Any pending output beat is discarded and no done pulse is generated.

Test Plan:
- cmd_addr=0x0100, cmd_len=3, id=0x5, slave OKAY, out_ready=1 -> one AR (araddr=0x0100, arlen=3, arsize=2, arburst=1); 4 beats out, last on beat 4; done=1 for 1 cycle; err=0.
- cmd_addr=0x0FF8, cmd_len=3 (32-bit) -> AR0 araddr=0x0FF8 arlen=1, then AR1 araddr=0x1000 arlen=1; out_last only on beat 4.
- cmd_len=7 with out_ready toggling 1/0 every cycle, rvalid always 1 -> rready follows (!out_valid||out_ready); data order 0..7 preserved, no beat duplicated or dropped.
- Slave returns rresp=2'b10 on beat 2 of 4 -> all 4 beats delivered; err=1 at done and held until next accept; next clean command -> err=0.
- Slave asserts rlast on beat 3 of arlen=3 -> err=1; module still completes after 4 beats; id mismatch (rid=0x6) -> err=1.
- rst asserted while in DATA after 2 of 8 beats -> next cycle arvalid=0, out_valid=0, busy=0, no done; next cycle cmd_ready=1; new command completes normally.

Source files
------------

// File: rtl/axi_read_master_if.sv
// AXI4 read-address and read-data channel bundle between an initiator (master)
// and a memory port (slave).
interface axi_read_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_master.sv
// AXI4 read initiator: one command in flight, split into two INCR bursts when it
// crosses a 4 KB boundary; R beats are forwarded through a registered output stage.
module axi_read_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  axi_read_master_if.master     m_axi,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic [8:0]            rem_q, rem_d;
  logic [8:0]            beats_left_q, beats_left_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic [12:0]           bytes_to_4k;
  logic [12:0]           beats_to_4k;
  logic [8:0]            total_beats;
  logic                  split;
  logic                  rready;
  logic                  r_hs;
  logic                  burst_final;
  logic                  accept;
  logic                  beat_bad;

  // Burst sizing for a new command: beats left before the 4 KB page ends.
  always_comb begin
    cmd_addr_al = cmd_addr & ALIGN_MASK;
    bytes_to_4k = 13'h1000 - {1'b0, cmd_addr_al[11:0]};
    beats_to_4k = bytes_to_4k >> SIZE;
    total_beats = {1'b0, cmd_len} + 9'd1;
    split       = {4'b0000, total_beats} > beats_to_4k;
  end

  always_comb begin
    rready      = (state_q == DATA) && (!out_valid_q || out_ready);
    r_hs        = rready && m_axi.rvalid;
    burst_final = (beats_left_q == 9'd1);
    accept      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    beat_bad    = (m_axi.rresp != 2'b00) || (m_axi.rid != id_q) ||
                  (m_axi.rlast != burst_final);
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    araddr_d     = araddr_q;
    next_addr_d  = next_addr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    rem_d        = rem_q;
    beats_left_d = beats_left_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    err_d        = err_q;
    busy_d       = busy_q;

    // Output stage drains independently of the FSM; a new R beat overrides below.
    if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d      = cmd_id;
          araddr_d  = cmd_addr_al;
          arvalid_d = 1'b1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          state_d   = ADDR;
          if (split) begin
            arlen_d     = 8'(beats_to_4k - 13'd1);
            rem_d       = total_beats - 9'(beats_to_4k);
            next_addr_d = cmd_addr_al + ADDR_WIDTH'(bytes_to_4k);
          end else begin
            arlen_d = cmd_len;
            rem_d   = '0;
          end
        end
      end
      ADDR: begin
        if (m_axi.arready) begin
          arvalid_d    = 1'b0;
          beats_left_d = {1'b0, arlen_q} + 9'd1;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          out_data_d   = m_axi.rdata;
          out_valid_d  = 1'b1;
          out_last_d   = 1'b0;
          beats_left_d = beats_left_q - 9'd1;
          if (beat_bad) err_d = 1'b1;
          // Burst length is trusted over rlast; rlast only feeds the error flag.
          if (burst_final) begin
            if (rem_q != 9'd0) begin
              araddr_d  = next_addr_q;
              arlen_d   = 8'(rem_q - 9'd1);
              rem_d     = '0;
              arvalid_d = 1'b1;
              state_d   = ADDR;
            end else begin
              out_last_d = 1'b1;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              state_d    = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      id_q         <= '0;
      araddr_q     <= '0;
      next_addr_q  <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      rem_q        <= '0;
      beats_left_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      id_q         <= id_d;
      araddr_q     <= araddr_d;
      next_addr_q  <= next_addr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      rem_q        <= rem_d;
      beats_left_q <= beats_left_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign m_axi.arid      = id_q;
  assign m_axi.araddr    = araddr_q;
  assign m_axi.arlen     = arlen_q;
  assign m_axi.arsize    = 3'(SIZE);
  assign m_axi.arburst   = 2'b01;
  assign m_axi.arlock    = 1'b0;
  assign m_axi.arcache   = 4'b0011;
  assign m_axi.arprot    = 3'b000;
  assign m_axi.arvalid   = arvalid_q;
  assign m_axi.rready    = rready;
  assign out_data        = out_data_q;
  assign out_last        = out_last_q;
  assign out_valid       = out_valid_q;
  assign done            = done_q;
  assign err             = err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: a task-driven AXI slave model feeds R beats,
// a negedge monitor captures the output stream, done pulses and the rready rule.
module tb_axi_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_id;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        err;
  logic        busy;

  axi_read_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) m ();

  axi_read_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .ID_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_id   (cmd_id),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .m_axi    (m),
    .out_data (out_data),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  logic [15:0] ar_addr[$];
  logic [7:0]  ar_len[$];
  int          done_cnt;
  logic        err_at_done;
  bit          chk_rready;

  // Slave fault knobs: global beat index within the command, -1 = off.
  int          resp_beat;
  int          flip_beat;
  int          badid_beat;
  logic [31:0] data_base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        err_at_done = err;
      end
      if (chk_rready && m.rvalid)
        check("rready_rule", 64'(m.rready), 64'(!out_valid || out_ready));
    end
  end

  function automatic logic [31:0] q_data(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic bit q_last(input int i);
    return (i < got_last.size()) ? got_last[i] : 1'b0;
  endfunction

  task automatic clear_run();
    got_data.delete();
    got_last.delete();
    ar_addr.delete();
    ar_len.delete();
    done_cnt    = 0;
    err_at_done = 1'bx;
    resp_beat   = -1;
    flip_beat   = -1;
    badid_beat  = -1;
  endtask

  task automatic send_cmd(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id);
    int unsigned n = 0;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_id    = id;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        check("cmd_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_err_clr", 64'(err), 64'd0);
    check("accept_cmd_ready", 64'(cmd_ready), 64'd0);
  endtask

  // Serves nb bursts; stop_after > 0 abandons the command after that many beats.
  task automatic serve(input int nb, input int stop_after);
    int          beat = 0;
    int unsigned n;
    logic [7:0]  len;
    logic [7:0]  id;
    for (int b = 0; b < nb; b++) begin
      n = 0;
      while (!m.arvalid) begin
        @(posedge clk); #1;
        n++;
        if (n > 200) begin
          check("ar_wait", 64'(m.arvalid), 64'd1);
          return;
        end
      end
      len = m.arlen;
      id  = m.arid;
      ar_addr.push_back(m.araddr);
      ar_len.push_back(m.arlen);
      check("arsize", 64'(m.arsize), 64'd2);
      check("arburst", 64'(m.arburst), 64'd1);
      check("arcache", 64'(m.arcache), 64'd3);
      m.arready = 1'b1;
      @(posedge clk); #1;
      m.arready = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
        m.rvalid = 1'b1;
        m.rdata  = data_base + 32'(beat);
        m.rid    = (beat == badid_beat) ? 8'h06 : id;
        m.rresp  = (beat == resp_beat) ? 2'b10 : 2'b00;
        m.rlast  = (k == int'(len)) != (beat == flip_beat);
        n = 0;
        forever begin
          @(negedge clk);
          if (m.rready) break;
          n++;
          if (n > 200) begin
            check("r_wait", 64'(m.rready), 64'd1);
            m.rvalid = 1'b0;
            return;
          end
        end
        @(posedge clk); #1;
        beat++;
        if (beat == stop_after) begin
          m.rvalid = 1'b0;
          m.rlast  = 1'b0;
          return;
        end
      end
      m.rvalid = 1'b0;
      m.rlast  = 1'b0;
    end
  endtask

  task automatic do_cmd(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id,
                        input int nb);
    fork
      send_cmd(addr, len, id);
      serve(nb, 0);
    join
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input int n, input logic [31:0] base);
    check("beat_count", 64'(got_data.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      check("beat_data", 64'(q_data(k)), 64'(base + 32'(k)));
      check("beat_last", 64'(q_last(k)), 64'(k == n - 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_id     = '0;
    cmd_valid  = 1'b0;
    out_ready  = 1'b1;
    chk_rready = 1'b0;
    m.arready  = 1'b0;
    m.rid      = '0;
    m.rdata    = '0;
    m.rresp    = '0;
    m.rlast    = 1'b0;
    m.rvalid   = 1'b0;
    clear_run();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_arvalid", 64'(m.arvalid), 64'd0);
    check("rst_araddr", 64'(m.araddr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Single burst, clean
    clear_run();
    data_base = 32'hA000_0000;
    do_cmd(16'h0100, 8'd3, 8'h05, 1);
    check("t1_ar_count", 64'(ar_addr.size()), 64'd1);
    check("t1_araddr", 64'(ar_addr[0]), 64'h0100);
    check("t1_arlen", 64'(ar_len[0]), 64'd3);
    check_stream(4, 32'hA000_0000);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_err", 64'(err_at_done), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_ready_after", 64'(cmd_ready), 64'd1);

    // 4 KB crossing split into 2+2 beats
    clear_run();
    data_base = 32'hB000_0000;
    do_cmd(16'h0FF8, 8'd3, 8'h07, 2);
    check("t2_ar_count", 64'(ar_addr.size()), 64'd2);
    if (ar_addr.size() == 2) begin
      check("t2_araddr0", 64'(ar_addr[0]), 64'h0FF8);
      check("t2_arlen0", 64'(ar_len[0]), 64'd1);
      check("t2_araddr1", 64'(ar_addr[1]), 64'h1000);
      check("t2_arlen1", 64'(ar_len[1]), 64'd1);
    end
    check_stream(4, 32'hB000_0000);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_err", 64'(err_at_done), 64'd0);

    // Unaligned address low bits dropped, crossing with 1 beat before the page end
    clear_run();
    data_base = 32'hB100_0000;
    do_cmd(16'h1FFE, 8'd4, 8'h07, 2);
    check("t2b_ar_count", 64'(ar_addr.size()), 64'd2);
    if (ar_addr.size() == 2) begin
      check("t2b_araddr0", 64'(ar_addr[0]), 64'h1FFC);
      check("t2b_arlen0", 64'(ar_len[0]), 64'd0);
      check("t2b_araddr1", 64'(ar_addr[1]), 64'h2000);
      check("t2b_arlen1", 64'(ar_len[1]), 64'd3);
    end
    check_stream(5, 32'hB100_0000);

    // Downstream backpressure toggling every cycle
    clear_run();
    data_base  = 32'hC000_0000;
    chk_rready = 1'b1;
    fork
      send_cmd(16'h0200, 8'd7, 8'h11);
      serve(1, 0);
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = !out_ready;
        end
      end
    join
    chk_rready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_stream(8, 32'hC000_0000);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // SLVERR on beat 2: all beats delivered, err sticky until next accept
    clear_run();
    data_base = 32'hD000_0000;
    resp_beat = 1;
    do_cmd(16'h0300, 8'd3, 8'h05, 1);
    check_stream(4, 32'hD000_0000);
    check("t4_err_at_done", 64'(err_at_done), 64'd1);
    check("t4_err_held", 64'(err), 64'd1);
    clear_run();
    data_base = 32'hD100_0000;
    do_cmd(16'h0340, 8'd1, 8'h05, 1);
    check_stream(2, 32'hD100_0000);
    check("t4_clean_err", 64'(err_at_done), 64'd0);

    // Early rlast on beat 3 of 4
    clear_run();
    data_base = 32'hE000_0000;
    flip_beat = 2;
    do_cmd(16'h0400, 8'd3, 8'h05, 1);
    check_stream(4, 32'hE000_0000);
    check("t5_early_last_err", 64'(err_at_done), 64'd1);

    // Missing rlast on the final beat
    clear_run();
    data_base = 32'hE100_0000;
    flip_beat = 3;
    do_cmd(16'h0500, 8'd3, 8'h05, 1);
    check_stream(4, 32'hE100_0000);
    check("t5_no_last_err", 64'(err_at_done), 64'd1);
    check("t5_no_last_done", 64'(done_cnt), 64'd1);

    // RID mismatch
    clear_run();
    data_base  = 32'hE200_0000;
    badid_beat = 0;
    do_cmd(16'h0600, 8'd3, 8'h05, 1);
    check_stream(4, 32'hE200_0000);
    check("t6_rid_err", 64'(err_at_done), 64'd1);

    // Reset during DATA after 2 of 8 beats
    clear_run();
    data_base = 32'hF000_0000;
    fork
      send_cmd(16'h0700, 8'd7, 8'h22);
      serve(1, 2);
    join
    check("t7_pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("t7_arvalid", 64'(m.arvalid), 64'd0);
    check("t7_out_valid", 64'(out_valid), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t7_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t7_no_done", 64'(done_cnt), 64'd0);
    clear_run();
    data_base = 32'hF100_0000;
    do_cmd(16'h0800, 8'd3, 8'h33, 1);
    check_stream(4, 32'hF100_0000);
    check("t7_after_done", 64'(done_cnt), 64'd1);
    check("t7_after_err", 64'(err_at_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
